// File: rtl/tile_map_store.sv
// Writable COLS x ROWS tile map with ROM scene loader (one row per clock),
// border-protected single-cell write port, registered read port and flat map output.
module tile_map_store #(
    parameter int COLS          = 20,
    parameter int ROWS          = 15,
    parameter int CELL_W        = 3,
    parameter int NUM_SCENES    = 4,
    parameter int DEFAULT_SCENE = 1,
    localparam int XW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int SW = (NUM_SCENES > 1) ? $clog2(NUM_SCENES) : 1,
    localparam int N  = COLS * ROWS * CELL_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_req_i,
    input  logic [SW-1:0]     load_scene_i,
    output logic              busy_o,
    output logic              load_done_o,
    input  logic              wr_en_i,
    input  logic [XW-1:0]     wr_x_i,
    input  logic [YW-1:0]     wr_y_i,
    input  logic [CELL_W-1:0] wr_data_i,
    output logic              wr_err_o,
    input  logic [XW-1:0]     rd_x_i,
    input  logic [YW-1:0]     rd_y_i,
    output logic [CELL_W-1:0] rd_data_o,
    output logic [0:N-1]      map_o
);

    typedef enum logic [1:0] {
        AUTO = 2'd0,
        IDLE = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam logic [CELL_W-1:0] C_NONE = '0;
    localparam logic [CELL_W-1:0] C_LINE = CELL_W'(1);
    localparam logic [CELL_W-1:0] C_TERM = CELL_W'(2);
    localparam logic [YW-1:0]     LAST_ROW = YW'(ROWS - 1);

    state_t              state_q;
    logic [YW-1:0]       row_q;
    logic [SW-1:0]       scene_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [CELL_W-1:0]   rd_data_q;
    logic [CELL_W-1:0]   rd_data_d;
    logic                wr_accept;
    logic [CELL_W-1:0]   cells_q [ROWS][COLS];
    logic [COLS-1:0][CELL_W-1:0] rom_cells;

    // Border cells are never set: the loop only visits interior columns and rows.
    function automatic logic [COLS-1:0][CELL_W-1:0] rom_row(input logic [SW-1:0] scene,
                                                            input logic [YW-1:0] row);
        logic [COLS-1:0][CELL_W-1:0] r;
        int y;
        int s;
        y = int'(row);
        s = int'(scene);
        r = '0;
        for (int x = 1; x < COLS - 1; x++) begin
            if (y >= 1 && y <= ROWS - 2 && s < NUM_SCENES) begin
                case (s)
                    1: begin
                        if ((y == 2 && x >= 3 && x <= 13) ||
                            (x == 3 && y >= 2 && y <= 12) ||
                            (x == 13 && y >= 3 && y <= 10))
                            r[x] = C_LINE;
                        if (x == 13 && y == 11)
                            r[x] = C_TERM;
                    end
                    2: if (((x + y) % 2) == 0) r[x] = C_LINE;
                    3: if (x == y || x == COLS - 1 - y) r[x] = C_TERM;
                    default: r[x] = C_NONE;
                endcase
            end
        end
        return r;
    endfunction

    assign rom_cells = rom_row(scene_q, row_q);

    assign wr_accept = (state_q == IDLE) && wr_en_i &&
                       (int'(wr_x_i) >= 1) && (int'(wr_x_i) <= COLS - 2) &&
                       (int'(wr_y_i) >= 1) && (int'(wr_y_i) <= ROWS - 2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= AUTO;
            row_q   <= '0;
            scene_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= wr_en_i && !wr_accept;
            case (state_q)
                AUTO: begin
                    scene_q <= SW'(DEFAULT_SCENE);
                    row_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= LOAD;
                end
                IDLE: begin
                    if (load_req_i) begin
                        scene_q <= load_scene_i;
                        row_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (row_q == LAST_ROW) begin
                        row_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        row_q <= row_q + YW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Loading and cell writes are mutually exclusive: writes are only accepted in IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int y = 0; y < ROWS; y++)
                for (int x = 0; x < COLS; x++)
                    cells_q[y][x] <= '0;
        end else if (state_q == LOAD) begin
            for (int x = 0; x < COLS; x++)
                cells_q[row_q][x] <= rom_cells[x];
        end else if (wr_accept) begin
            cells_q[wr_y_i][wr_x_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (int'(rd_x_i) < COLS && int'(rd_y_i) < ROWS)
            rd_data_d = cells_q[rd_y_i][rd_x_i];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            rd_data_q <= '0;
        else
            rd_data_q <= rd_data_d;
    end

    always_comb begin
        map_o = '0;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                map_o[(x + COLS * y) * CELL_W +: CELL_W] = cells_q[y][x];
    end

    assign busy_o      = busy_q;
    assign load_done_o = done_q;
    assign wr_err_o    = err_q;
    assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_tile_map_store.sv
// Bench for tile_map_store: table-driven read vectors through a scoreboard queue
// plus hand sequences for load timing, write rejection and mid-load reset.
module tb_tile_map_store;
    localparam int COLS = 20;
    localparam int ROWS = 15;
    localparam int CELL_W = 3;
    localparam int N = COLS * ROWS * CELL_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_req = 1'b0;
    logic [1:0]        load_scene = '0;
    logic              busy;
    logic              load_done;
    logic              wr_en = 1'b0;
    logic [4:0]        wr_x = '0;
    logic [3:0]        wr_y = '0;
    logic [CELL_W-1:0] wr_data = '0;
    logic              wr_err;
    logic [4:0]        rd_x = '0;
    logic [3:0]        rd_y = '0;
    logic [CELL_W-1:0] rd_data;
    logic [0:N-1]      map;

    int tests = 0;
    int fails = 0;
    logic [CELL_W-1:0] exp_q[$];

    typedef struct {
        int x;
        int y;
        int e;
    } rd_vec_t;
    rd_vec_t rtbl[11];

    tile_map_store #(.COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .NUM_SCENES(4), .DEFAULT_SCENE(1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .load_req_i(load_req), .load_scene_i(load_scene),
        .busy_o(busy), .load_done_o(load_done),
        .wr_en_i(wr_en), .wr_x_i(wr_x), .wr_y_i(wr_y), .wr_data_i(wr_data),
        .wr_err_o(wr_err),
        .rd_x_i(rd_x), .rd_y_i(rd_y), .rd_data_o(rd_data),
        .map_o(map)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [CELL_W-1:0] mcell(input int x, input int y);
        return map[(x + COLS * y) * CELL_W +: CELL_W];
    endfunction

    function automatic int map_nonzero();
        int n;
        n = 0;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                if (mcell(x, y) != '0) n++;
        return n;
    endfunction

    task automatic read_chk(input string name, input int x, input int y, input int e);
        logic [CELL_W-1:0] want;
        rd_x = 5'(x);
        rd_y = 4'(y);
        exp_q.push_back(CELL_W'(e));
        tick;
        want = exp_q.pop_front();
        check(name, 32'(rd_data), 32'(want));
    endtask

    task automatic run_load(input bit do_req, input logic [1:0] scene, input int extra_at,
                            output int first_busy, output int nbusy, output int ndone,
                            output int done_at);
        first_busy = -1;
        nbusy = 0;
        ndone = 0;
        done_at = -1;
        if (do_req) begin
            load_req = 1'b1;
            load_scene = scene;
        end
        for (int i = 1; i <= 30; i++) begin
            if (i == extra_at) load_req = 1'b1;
            tick;
            load_req = 1'b0;
            if (busy) begin
                nbusy++;
                if (first_busy < 0) first_busy = i;
            end
            if (load_done) begin
                ndone++;
                done_at = i;
            end
        end
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick;
            if (load_done) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fb, nb, nd, da;
        int bx[4];
        int by[4];

        rtbl[0]  = '{13, 11, 2};
        rtbl[1]  = '{0, 0, 0};
        rtbl[2]  = '{3, 3, 1};
        rtbl[3]  = '{5, 2, 1};
        rtbl[4]  = '{13, 5, 1};
        rtbl[5]  = '{19, 14, 0};
        rtbl[6]  = '{3, 12, 1};
        rtbl[7]  = '{3, 13, 0};
        rtbl[8]  = '{14, 2, 0};
        rtbl[9]  = '{25, 3, 0};
        rtbl[10] = '{13, 12, 0};

        // reset state
        repeat (3) tick;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(load_done), 0);
        check("rst_wr_err", 32'(wr_err), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_map", map_nonzero(), 0);

        // automatic default-scene load after release
        rst_n = 1'b1;
        run_load(1'b0, 2'd0, 0, fb, nb, nd, da);
        check("auto_first_busy", fb, 1);
        check("auto_busy_cycles", nb, 15);
        check("auto_done_count", nd, 1);
        check("auto_done_at", da, 16);
        for (int i = 0; i < 11; i++)
            read_chk($sformatf("rd_tbl%0d", i), rtbl[i].x, rtbl[i].y, rtbl[i].e);
        check("map_term", 32'(mcell(13, 11)), 2);

        // blank scene with an ignored mid-load request
        run_load(1'b1, 2'd0, 6, fb, nb, nd, da);
        check("blank_first_busy", fb, 1);
        check("blank_busy_cycles", nb, 15);
        check("blank_done_count", nd, 1);
        check("blank_done_at", da, 16);
        check("blank_map", map_nonzero(), 0);
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                read_chk($sformatf("blank_rd_%0d_%0d", x, y), x, y, 0);

        // accepted interior write, read of same cell in the write cycle sees old value
        wr_en = 1'b1; wr_x = 5'd5; wr_y = 4'd7; wr_data = 3'd1;
        rd_x = 5'd5; rd_y = 4'd7;
        exp_q.push_back(3'd0);
        tick;
        wr_en = 1'b0;
        check("wr_same_cycle_rd", 32'(rd_data), 32'(exp_q.pop_front()));
        check("wr_ok_err", 32'(wr_err), 0);
        check("wr_ok_map", 32'(mcell(5, 7)), 1);
        read_chk("wr_ok_rd", 5, 7, 1);
        check("wr_ok_err2", 32'(wr_err), 0);

        // rejected writes: border and out of range
        bx = '{0, 19, 4, 25};
        by = '{4, 4, 14, 3};
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_x = 5'(bx[i]); wr_y = 4'(by[i]); wr_data = 3'd1;
            tick;
            wr_en = 1'b0;
            check($sformatf("bad_wr_err_%0d", i), 32'(wr_err), 1);
            tick;
            check($sformatf("bad_wr_pulse_%0d", i), 32'(wr_err), 0);
        end
        check("bad_wr_0_4", 32'(mcell(0, 4)), 0);
        check("bad_wr_19_4", 32'(mcell(19, 4)), 0);
        check("bad_wr_4_14", 32'(mcell(4, 14)), 0);
        read_chk("bad_wr_25_3", 25, 3, 0);
        check("bad_wr_5_7_kept", 32'(mcell(5, 7)), 1);

        // write during LOAD after row 3 has already been written
        load_req = 1'b1; load_scene = 2'd1;
        tick;
        load_req = 1'b0;
        check("lw_busy", 32'(busy), 1);
        repeat (6) tick;
        wr_en = 1'b1; wr_x = 5'd3; wr_y = 4'd3; wr_data = 3'd2;
        tick;
        wr_en = 1'b0;
        check("lw_err", 32'(wr_err), 1);
        wait_done("lw_done");
        check("lw_map_3_3", 32'(mcell(3, 3)), 1);
        read_chk("lw_rd_3_3", 3, 3, 1);

        // write and load request in the same IDLE cycle
        wr_en = 1'b1; wr_x = 5'd3; wr_y = 4'd3; wr_data = 3'd2;
        load_req = 1'b1; load_scene = 2'd1;
        tick;
        wr_en = 1'b0; load_req = 1'b0;
        check("wl_err", 32'(wr_err), 0);
        check("wl_applied", 32'(mcell(3, 3)), 2);
        check("wl_busy", 32'(busy), 1);
        wait_done("wl_done");
        check("wl_final_map", 32'(mcell(3, 3)), 1);
        read_chk("wl_final_rd", 3, 3, 1);

        // reset in the middle of a load
        load_req = 1'b1; load_scene = 2'd2;
        tick;
        load_req = 1'b0;
        repeat (8) tick;
        check("mr_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mr_map", map_nonzero(), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_done", 32'(load_done), 0);
        check("mr_rd_data", 32'(rd_data), 0);
        tick;
        tick;
        rst_n = 1'b1;
        run_load(1'b0, 2'd0, 0, fb, nb, nd, da);
        check("mr_first_busy", fb, 1);
        check("mr_busy_cycles", nb, 15);
        check("mr_done_count", nd, 1);
        check("mr_done_at", da, 16);
        read_chk("mr_rd_13_11", 13, 11, 2);
        read_chk("mr_rd_0_0", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
